// File: rtl/exe_mem_if.sv
// EXE->MEM pipeline bundle: upstream valid/ready plus payload, downstream valid/ready plus registered copies.
// The master modport is the side that drives the execute payload; the slave modport is the pipeline register.
interface exe_mem_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int MEM_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] addPc;
    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] readData2;
    logic [REG_W-1:0]  muxInst;
    logic [WB_W-1:0]   WB;
    logic [MEM_W-1:0]  MEM;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] addPcOut;
    logic [DATA_W-1:0] aluResultOut;
    logic [DATA_W-1:0] readData2Out;
    logic [REG_W-1:0]  muxInstOut;
    logic [WB_W-1:0]   WBOut;
    logic [MEM_W-1:0]  MEMOut;

    modport master (
        output in_valid, addPc, aluResult, readData2, muxInst, WB, MEM, out_ready,
        input  in_ready, out_valid, addPcOut, aluResultOut, readData2Out, muxInstOut, WBOut, MEMOut
    );

    modport slave (
        input  in_valid, addPc, aluResult, readData2, muxInst, WB, MEM, out_ready,
        output in_ready, out_valid, addPcOut, aluResultOut, readData2Out, muxInstOut, WBOut, MEMOut
    );
endinterface

// File: rtl/exe_mem_pipe.sv
// Flow-controlled EXE->MEM pipeline register with synchronous flush (bubble insertion).
// Define EXE_MEM_SKID_EN to add a skid entry, which makes in_ready independent of out_ready.
module exe_mem_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int MEM_W  = 3
) (
    input logic       clock,
    input logic       reset,
    input logic       flush,
    exe_mem_if.slave  bus
);

    typedef struct packed {
        logic [DATA_W-1:0] addPc;
        logic [DATA_W-1:0] aluResult;
        logic [DATA_W-1:0] readData2;
        logic [REG_W-1:0]  muxInst;
        logic [WB_W-1:0]   wb;
        logic [MEM_W-1:0]  mem;
    } bundle_t;

    bundle_t inBundle;
    bundle_t mainBundle_d, mainBundle_q;
    logic    outValid_d, outValid_q;
    logic    inReady;
    logic    accept;
    logic    drain;

    assign inBundle = '{addPc:     bus.addPc,
                        aluResult: bus.aluResult,
                        readData2: bus.readData2,
                        muxInst:   bus.muxInst,
                        wb:        bus.WB,
                        mem:       bus.MEM};

    assign accept = bus.in_valid && inReady;
    assign drain  = outValid_q && bus.out_ready;

`ifdef EXE_MEM_SKID_EN
    bundle_t skidBundle_d, skidBundle_q;
    logic    skidValid_d, skidValid_q;

    assign inReady = !flush && !skidValid_q;

    // An accept that main cannot absorb (stalled and full) parks in skid; skid refills main on drain.
    always_comb begin
        mainBundle_d = mainBundle_q;
        outValid_d   = outValid_q;
        skidBundle_d = skidBundle_q;
        skidValid_d  = skidValid_q;
        if (flush) begin
            outValid_d       = 1'b0;
            mainBundle_d.wb  = '0;
            mainBundle_d.mem = '0;
            skidValid_d      = 1'b0;
        end else if (accept && outValid_q && !bus.out_ready) begin
            skidBundle_d = inBundle;
            skidValid_d  = 1'b1;
        end else if (accept) begin
            mainBundle_d = inBundle;
            outValid_d   = 1'b1;
        end else if (drain && skidValid_q) begin
            mainBundle_d = skidBundle_q;
            outValid_d   = 1'b1;
            skidValid_d  = 1'b0;
        end else if (drain) begin
            outValid_d       = 1'b0;
            mainBundle_d.wb  = '0;
            mainBundle_d.mem = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            skidBundle_q <= '0;
            skidValid_q  <= 1'b0;
        end else begin
            skidBundle_q <= skidBundle_d;
            skidValid_q  <= skidValid_d;
        end
    end
`else
    assign inReady = !flush && (!outValid_q || bus.out_ready);

    // Control fields are cleared whenever valid drops so an empty stage reads as a NOP.
    always_comb begin
        mainBundle_d = mainBundle_q;
        outValid_d   = outValid_q;
        if (flush) begin
            outValid_d       = 1'b0;
            mainBundle_d.wb  = '0;
            mainBundle_d.mem = '0;
        end else if (accept) begin
            mainBundle_d = inBundle;
            outValid_d   = 1'b1;
        end else if (drain) begin
            outValid_d       = 1'b0;
            mainBundle_d.wb  = '0;
            mainBundle_d.mem = '0;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            mainBundle_q <= '0;
            outValid_q   <= 1'b0;
        end else begin
            mainBundle_q <= mainBundle_d;
            outValid_q   <= outValid_d;
        end
    end

    assign bus.in_ready     = inReady;
    assign bus.out_valid    = outValid_q;
    assign bus.addPcOut     = mainBundle_q.addPc;
    assign bus.aluResultOut = mainBundle_q.aluResult;
    assign bus.readData2Out = mainBundle_q.readData2;
    assign bus.muxInstOut   = mainBundle_q.muxInst;
    assign bus.WBOut        = mainBundle_q.wb;
    assign bus.MEMOut       = mainBundle_q.mem;

endmodule

// File: tb/tb_exe_mem_pipe.sv
// Directed, table-driven bench for exe_mem_pipe (32-bit instance) plus a 64-bit width instance.
// Expected in_ready/stall behaviour follows EXE_MEM_SKID_EN when it is defined for the build.
module tb_exe_mem_pipe;

    logic clock = 1'b0;
    logic reset;
    logic flush;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    exe_mem_if #(.DATA_W(32), .REG_W(5), .WB_W(2), .MEM_W(3)) bus ();
    exe_mem_if #(.DATA_W(64), .REG_W(6), .WB_W(2), .MEM_W(3)) bus64 ();

    exe_mem_pipe #(.DATA_W(32), .REG_W(5), .WB_W(2), .MEM_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    exe_mem_pipe #(.DATA_W(64), .REG_W(6), .WB_W(2), .MEM_W(3)) dut64 (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus64)
    );

    typedef struct {
        string       name;
        logic        inValid;
        logic        outReady;
        logic        flushIn;
        logic [31:0] alu;
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic        expInReady;
        logic        expOutValid;
        logic [31:0] expAlu;
        logic [1:0]  expWb;
        logic [2:0]  expMem;
    } vec_t;

    vec_t vecs[$];

    // Side payload fields are fixed functions of aluResult (all map 0 to 0) so one expected value covers them.
    function automatic logic [31:0] pcOf(input logic [31:0] a);
        return a << 2;
    endfunction

    function automatic logic [31:0] rdOf(input logic [31:0] a);
        return {a[15:0], a[31:16]};
    endfunction

    function automatic logic [4:0] regOf(input logic [31:0] a);
        return a[4:0] ^ a[9:5];
    endfunction

    function automatic vec_t mkVec(input string n, input logic iv, input logic orr, input logic fl,
                                   input logic [31:0] a, input logic [1:0] w, input logic [2:0] m,
                                   input logic er, input logic ev, input logic [31:0] ea,
                                   input logic [1:0] ew, input logic [2:0] em);
        vec_t v;
        v.name = n; v.inValid = iv; v.outReady = orr; v.flushIn = fl;
        v.alu = a; v.wb = w; v.mem = m;
        v.expInReady = er; v.expOutValid = ev; v.expAlu = ea; v.expWb = ew; v.expMem = em;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clock);
        flush         = v.flushIn;
        bus.in_valid  = v.inValid;
        bus.out_ready = v.outReady;
        bus.aluResult = v.alu;
        bus.addPc     = pcOf(v.alu);
        bus.readData2 = rdOf(v.alu);
        bus.muxInst   = regOf(v.alu);
        bus.WB        = v.wb;
        bus.MEM       = v.mem;
        #1;
        checkOutput($sformatf("%s[%0d].in_ready", v.name, idx), 64'(bus.in_ready), 64'(v.expInReady));
        @(posedge clock);
        #1;
        checkOutput($sformatf("%s[%0d].out_valid", v.name, idx), 64'(bus.out_valid), 64'(v.expOutValid));
        checkOutput($sformatf("%s[%0d].aluResultOut", v.name, idx), 64'(bus.aluResultOut), 64'(v.expAlu));
        checkOutput($sformatf("%s[%0d].addPcOut", v.name, idx), 64'(bus.addPcOut), 64'(pcOf(v.expAlu)));
        checkOutput($sformatf("%s[%0d].readData2Out", v.name, idx), 64'(bus.readData2Out), 64'(rdOf(v.expAlu)));
        checkOutput($sformatf("%s[%0d].muxInstOut", v.name, idx), 64'(bus.muxInstOut), 64'(regOf(v.expAlu)));
        checkOutput($sformatf("%s[%0d].WBOut", v.name, idx), 64'(bus.WBOut), 64'(v.expWb));
        checkOutput($sformatf("%s[%0d].MEMOut", v.name, idx), 64'(bus.MEMOut), 64'(v.expMem));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
        checkOutput({tag, ".aluResultOut"}, 64'(bus.aluResultOut), 64'd0);
        checkOutput({tag, ".addPcOut"}, 64'(bus.addPcOut), 64'd0);
        checkOutput({tag, ".readData2Out"}, 64'(bus.readData2Out), 64'd0);
        checkOutput({tag, ".muxInstOut"}, 64'(bus.muxInstOut), 64'd0);
        checkOutput({tag, ".WBOut"}, 64'(bus.WBOut), 64'd0);
        checkOutput({tag, ".MEMOut"}, 64'(bus.MEMOut), 64'd0);
    endtask

    initial begin
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mkVec("stream", 1, 1, 0, 32'(i), 2'b10, 3'b100, 1, 1, 32'(i), 2'b10, 3'b100));
        vecs.push_back(mkVec("drain", 0, 1, 0, 32'h0, 2'b00, 3'b000, 1, 0, 32'd8, 2'b00, 3'b000));
        vecs.push_back(mkVec("stallLoad", 1, 0, 0, 32'hA5A5A5A5, 2'b11, 3'b011, 1, 1, 32'hA5A5A5A5, 2'b11, 3'b011));
`ifdef EXE_MEM_SKID_EN
        vecs.push_back(mkVec("stall", 1, 0, 0, 32'h11111111, 2'b01, 3'b010, 1, 1, 32'hA5A5A5A5, 2'b11, 3'b011));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mkVec("stall", 1, 0, 0, 32'h11111111, 2'b01, 3'b010, 0, 1, 32'hA5A5A5A5, 2'b11, 3'b011));
        vecs.push_back(mkVec("release", 0, 1, 0, 32'h0, 2'b00, 3'b000, 0, 1, 32'h11111111, 2'b01, 3'b010));
        vecs.push_back(mkVec("idle", 0, 1, 0, 32'h0, 2'b00, 3'b000, 1, 0, 32'h11111111, 2'b00, 3'b000));
        vecs.push_back(mkVec("flushLoad", 1, 0, 0, 32'hDEADBEEF, 2'b01, 3'b010, 1, 1, 32'hDEADBEEF, 2'b01, 3'b010));
        vecs.push_back(mkVec("flushHold", 0, 0, 0, 32'h0, 2'b00, 3'b000, 1, 1, 32'hDEADBEEF, 2'b01, 3'b010));
`else
        for (int i = 0; i < 4; i++)
            vecs.push_back(mkVec("stall", 1, 0, 0, 32'h11111111, 2'b01, 3'b010, 0, 1, 32'hA5A5A5A5, 2'b11, 3'b011));
        vecs.push_back(mkVec("release", 0, 1, 0, 32'h0, 2'b00, 3'b000, 1, 0, 32'hA5A5A5A5, 2'b00, 3'b000));
        vecs.push_back(mkVec("idle", 0, 1, 0, 32'h0, 2'b00, 3'b000, 1, 0, 32'hA5A5A5A5, 2'b00, 3'b000));
        vecs.push_back(mkVec("flushLoad", 1, 0, 0, 32'hDEADBEEF, 2'b01, 3'b010, 1, 1, 32'hDEADBEEF, 2'b01, 3'b010));
        vecs.push_back(mkVec("flushHold", 0, 0, 0, 32'h0, 2'b00, 3'b000, 0, 1, 32'hDEADBEEF, 2'b01, 3'b010));
`endif
        vecs.push_back(mkVec("flush", 1, 0, 1, 32'hCAFEF00D, 2'b11, 3'b111, 0, 0, 32'hDEADBEEF, 2'b00, 3'b000));
        vecs.push_back(mkVec("postFlush", 0, 1, 0, 32'h0, 2'b00, 3'b000, 1, 0, 32'hDEADBEEF, 2'b00, 3'b000));

        bus64.in_valid  = 1'b0;
        bus64.out_ready = 1'b0;
        bus64.addPc     = '0;
        bus64.aluResult = '0;
        bus64.readData2 = '0;
        bus64.muxInst   = '0;
        bus64.WB        = '0;
        bus64.MEM       = '0;

        // Reset held for two cycles with random inputs on the bus.
        reset = 1'b1;
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            flush         = 1'($urandom_range(0, 1));
            bus.addPc     = $urandom;
            bus.aluResult = $urandom;
            bus.readData2 = $urandom;
            bus.muxInst   = 5'($urandom);
            bus.WB        = 2'($urandom);
            bus.MEM       = 3'($urandom);
        end
        @(negedge clock);
        reset         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        checkOutput("reset.in_ready", 64'(bus.in_ready), 64'd1);
        checkAllZero("reset");

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], i);

        // Reset while stalled discards both the held bundle and any skidded one.
        @(negedge clock);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        bus.aluResult = 32'h0BADCAFE;
        bus.WB        = 2'b10;
        bus.MEM       = 3'b110;
        @(posedge clock); #1;
        checkOutput("midStall.load", 64'(bus.aluResultOut), 64'h0BADCAFE);
        @(negedge clock);
        bus.aluResult = 32'h22222222;
        @(posedge clock); #1;
        checkOutput("midStall.hold", 64'(bus.aluResultOut), 64'h0BADCAFE);
        @(negedge clock);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clock); #1;
        checkAllZero("midStall.reset");
        @(negedge clock);
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checkOutput("midStall.in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clock); #1;
        checkAllZero("midStall.after");

        @(negedge clock);
        bus64.in_valid  = 1'b1;
        bus64.out_ready = 1'b1;
        bus64.addPc     = 64'hFFFF_0000_1234_5678;
        bus64.aluResult = 64'h0123_4567_89AB_CDEF;
        bus64.readData2 = 64'h8000_0000_0000_0001;
        bus64.muxInst   = 6'h2A;
        bus64.WB        = 2'b01;
        bus64.MEM       = 3'b101;
        #1;
        checkOutput("wide.in_ready", 64'(bus64.in_ready), 64'd1);
        @(posedge clock); #1;
        checkOutput("wide.out_valid", 64'(bus64.out_valid), 64'd1);
        checkOutput("wide.addPcOut", bus64.addPcOut, 64'hFFFF_0000_1234_5678);
        checkOutput("wide.aluResultOut", bus64.aluResultOut, 64'h0123_4567_89AB_CDEF);
        checkOutput("wide.readData2Out", bus64.readData2Out, 64'h8000_0000_0000_0001);
        checkOutput("wide.muxInstOut", 64'(bus64.muxInstOut), 64'h2A);
        checkOutput("wide.WBOut", 64'(bus64.WBOut), 64'h1);
        checkOutput("wide.MEMOut", 64'(bus64.MEMOut), 64'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
